// File: rtl/inst_fifo.sv
// inst_fifo: dual-issue instruction queue between fetch and decode.
// Accepts up to two fetched instructions per cycle and presents the two
// oldest, in program order, as first-word-fall-through outputs. A redirect
// (flush) empties the queue on the next edge.
module inst_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        push_en1,
  input  logic        push_en2,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_inst1,
  input  logic [31:0] push_inst2,
  input  logic        pop_en1,
  input  logic        pop_en2,
  output logic        full,
  output logic        empty,
  output logic        out_valid1,
  output logic        out_valid2,
  output logic [31:0] out_pc1,
  output logic [31:0] out_pc2,
  output logic [31:0] out_inst1,
  output logic [31:0] out_inst2
);
  localparam int          AW      = $clog2(DEPTH);
  localparam int          LANES   = 2;
  localparam logic [AW:0] FULL_TH = (AW+1)'(DEPTH-2);

  // storage is not reset: entries are only visible through count
  logic [31:0]   r_pc   [DEPTH];
  logic [31:0]   r_inst [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;

  logic                        w_p1, w_p2, w_q1, w_q2;
  logic [AW-1:0]               w_wr_ptr1;
  logic [AW:0]                 w_nin, w_nout;
  logic [LANES-1:0]            w_vld;
  logic [LANES-1:0][AW-1:0]    w_rd_idx;
  logic [LANES-1:0][31:0]      w_pc, w_inst;

  // Status comes only from registered count, so it never depends on
  // same-cycle inputs. Threshold DEPTH-2 guarantees a full pair fits.
  assign full     = r_count > FULL_TH;
  assign empty    = r_count == '0;
  assign w_vld[0] = r_count != '0;
  assign w_vld[1] = r_count > (AW+1)'(1);

  // Effective handshakes; flush drops everything this cycle.
  assign w_p1 = push_en1 & ~full & ~flush;
  assign w_p2 = w_p1 & push_en2;
  assign w_q1 = pop_en1 & w_vld[0] & ~flush;
  assign w_q2 = w_q1 & pop_en2 & w_vld[1];

  assign w_nin     = {{AW{1'b0}}, w_p1} + {{AW{1'b0}}, w_p2};
  assign w_nout    = {{AW{1'b0}}, w_q1} + {{AW{1'b0}}, w_q2};
  // DEPTH is a power of two, so AW-bit pointer arithmetic wraps for free
  assign w_wr_ptr1 = r_wr_ptr + AW'(1);

  // Pointer and occupancy state; flush takes priority over push/pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_nin[AW-1:0];
      r_rd_ptr <= r_rd_ptr + w_nout[AW-1:0];
      r_count  <= r_count + w_nin - w_nout;
    end
  end

  // Entry writes: slot 1 at wr_ptr, slot 2 at the next (wrapped) entry.
  always_ff @(posedge clk) begin
    if (w_p1) begin
      r_pc[r_wr_ptr]   <= push_pc;
      r_inst[r_wr_ptr] <= push_inst1;
    end
    if (w_p2) begin
      r_pc[w_wr_ptr1]   <= push_pc + 32'd4;
      r_inst[w_wr_ptr1] <= push_inst2;
    end
  end

  // Read lanes: head and head+1, zeroed when not valid.
  for (genvar l = 0; l < LANES; l++) begin : g_rd
    assign w_rd_idx[l] = r_rd_ptr + AW'(l);
    assign w_pc[l]     = w_vld[l] ? r_pc[w_rd_idx[l]]   : '0;
    assign w_inst[l]   = w_vld[l] ? r_inst[w_rd_idx[l]] : '0;
  end

  assign out_valid1 = w_vld[0];
  assign out_valid2 = w_vld[1];
  assign out_pc1    = w_pc[0];
  assign out_pc2    = w_pc[1];
  assign out_inst1  = w_inst[0];
  assign out_inst2  = w_inst[1];
endmodule

// File: tb/tb_inst_fifo.sv
// tb_inst_fifo: directed bench with a queue scoreboard of {pc, inst}.
module tb_inst_fifo;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        push_en1 = 1'b0, push_en2 = 1'b0;
  logic [31:0] push_pc = '0, push_inst1 = '0, push_inst2 = '0;
  logic        pop_en1 = 1'b0, pop_en2 = 1'b0;
  logic        full, empty, out_valid1, out_valid2;
  logic [31:0] out_pc1, out_pc2, out_inst1, out_inst2;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb [$];
  logic [31:0] next_pc = 32'h0000_1000;

  inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .push_en1(push_en1), .push_en2(push_en2), .push_pc(push_pc),
    .push_inst1(push_inst1), .push_inst2(push_inst2),
    .pop_en1(pop_en1), .pop_en2(pop_en2),
    .full(full), .empty(empty), .out_valid1(out_valid1), .out_valid2(out_valid2),
    .out_pc1(out_pc1), .out_pc2(out_pc2), .out_inst1(out_inst1), .out_inst2(out_inst2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the scoreboard contents.
  task automatic chk_all(input string tag);
    logic [63:0] e0, e1;
    int n;
    n  = sb.size();
    e0 = (n >= 1) ? sb[0] : 64'd0;
    e1 = (n >= 2) ? sb[1] : 64'd0;
    chk({tag, ".v1"},    64'(out_valid1), 64'(n >= 1));
    chk({tag, ".v2"},    64'(out_valid2), 64'(n >= 2));
    chk({tag, ".head1"}, {out_pc1, out_inst1}, e0);
    chk({tag, ".head2"}, {out_pc2, out_inst2}, e1);
    chk({tag, ".full"},  64'(full),  64'(n > DEPTH-2));
    chk({tag, ".empty"}, 64'(empty), 64'(n == 0));
  endtask

  // One clock: drive inputs, predict, advance, then compare.
  task automatic cyc(input logic pe1, input logic pe2, input logic [31:0] pc,
                     input logic [31:0] i1, input logic [31:0] i2,
                     input logic po1, input logic po2, input logic fl, input string tag);
    bit p1, p2, q1, q2;
    int n;
    push_en1 = pe1; push_en2 = pe2; push_pc = pc; push_inst1 = i1; push_inst2 = i2;
    pop_en1 = po1; pop_en2 = po2; flush = fl;
    n  = sb.size();
    p1 = pe1 && (n <= DEPTH-2) && !fl;
    p2 = p1 && pe2;
    q1 = po1 && (n >= 1) && !fl;
    q2 = q1 && po2 && (n >= 2);
    @(posedge clk); #1;
    if (fl) sb.delete();
    else begin
      if (q1) void'(sb.pop_front());
      if (q2) void'(sb.pop_front());
      if (p1) sb.push_back({pc, i1});
      if (p2) sb.push_back({pc + 32'd4, i2});
    end
    push_en1 = 0; push_en2 = 0; pop_en1 = 0; pop_en2 = 0; flush = 0;
    chk_all(tag);
  endtask

  // Sequential-PC pair push with optional pops.
  task automatic pair(input logic po1, input logic po2, input string tag);
    cyc(1, 1, next_pc, $urandom, $urandom, po1, po2, 0, tag);
    if (sb.size() > 0 && sb[sb.size()-1][63:32] == next_pc + 32'd4) next_pc += 32'd8;
  endtask

  initial begin
    // reset state
    #12;
    chk_all("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    // dual push at boot vector
    cyc(1, 1, 32'hBFC0_0000, 32'h1111_1111, 32'h2222_2222, 0, 0, 0, "dual_push");
    chk("boot_pc2", 64'(out_pc2), 64'hBFC0_0004);
    cyc(0, 0, 0, 0, 0, 1, 1, 0, "pop2");

    // slot 2 without slot 1 ignored; then single push
    cyc(0, 1, 32'h100, 32'hAAAA_0001, 32'hAAAA_0002, 0, 0, 0, "push2_only");
    chk("push2_only_empty", 64'(empty), 64'd1);
    cyc(1, 0, 32'h200, 32'hBBBB_0001, 32'hBBBB_0002, 0, 0, 0, "push1_only");
    chk("push1_only_pc2", 64'(out_pc2), 64'd0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, "pop1");

    // fill with pairs (wr_ptr now odd, so one pair straddles 15/0)
    for (int i = 0; i < 9; i++) pair(0, 0, "fill");
    chk("fill_full", 64'(full), 64'd1);
    cyc(1, 0, 32'hDEAD_0000, 32'hDEAD_BEEF, 0, 0, 0, 0, "push_when_full");
    cyc(1, 1, 32'hDEAD_0010, 32'h1, 32'h2, 1, 1, 0, "push_full_with_pop");
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0, 1, 1, 0, "drain");
    chk("drain_empty", 64'(empty), 64'd1);

    // sustained traffic across pointer wrap, mixed 1/2 pops
    for (int i = 0; i < 40; i++) begin
      logic [31:0] prev;
      prev = out_pc1;
      if (i % 3 == 0) pair(1, 0, "wrap21");
      else            pair(1, 1, "wrap22");
      if (out_valid1 && prev != 0 && out_pc1 != prev)
        chk("wrap_order", 64'(out_pc1 - prev) % 4, 64'd0);
    end
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 1, 1, 0, "wrap_drain");
    chk("wrap_empty", 64'(empty), 64'd1);

    // flush with simultaneous push and pop at count 6
    for (int i = 0; i < 3; i++) pair(0, 0, "pre_flush");
    chk("count6", 64'(sb.size()), 64'd6);
    cyc(1, 1, 32'hF00D_0000, 32'h5, 32'h6, 1, 1, 1, "flush");
    chk("flush_empty", 64'(empty), 64'd1);

    // asynchronous reset mid-stream at count 5
    for (int i = 0; i < 2; i++) pair(0, 0, "pre_rst");
    cyc(1, 0, next_pc, 32'h7777_7777, 0, 0, 0, 0, "pre_rst1");
    next_pc += 32'd4;
    #2 resetn = 1'b0;
    #1;
    sb.delete();
    chk_all("async_rst");
    #1 resetn = 1'b1;
    cyc(1, 1, 32'hC0DE_0000, 32'h9999_0001, 32'h9999_0002, 0, 0, 0, "post_rst");
    chk("post_rst_head", {out_pc1, out_inst1}, {32'hC0DE_0000, 32'h9999_0001});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/inst_fifo.md
# inst_fifo

Dual-issue instruction queue between the fetch stage and the decode stage. Each cycle it accepts up to two fetched instructions (slot 1, and slot 2 when the fetch pair is 8-byte aligned). It presents up to two of the oldest instructions, in program order, to the dual-issue decoder, which pops zero, one or two per cycle. Branch and exception redirects flush the queue.

## Interface
- DEPTH, 16, number of entries; power of two, >= 4
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  discard all entries (redirect)
- push_en1  in  1  write slot-1 instruction this cycle
- push_en2  in  1  write slot-2 instruction; honoured only with push_en1
- push_pc  in  32  PC of slot-1 instruction; slot-2 PC is push_pc + 4
- push_inst1  in  32  slot-1 instruction word
- push_inst2  in  32  slot-2 instruction word
- pop_en1  in  1  decoder consumes head entry
- pop_en2  in  1  decoder consumes head+1 entry; honoured only with an effective pop 1
- full  out  1  fewer than 2 free entries; fetch must stall
- empty  out  1  count == 0
- out_valid1, out_valid2  out  1 each  head / head+1 entry present
- out_pc1, out_pc2  out  32 each  PCs of head / head+1
- out_inst1, out_inst2  out  32 each  instruction words of head / head+1

## Operation
- Storage: DEPTH entries of {pc[31:0], inst[31:0]}. wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Effective pushes:
  - p1 = push_en1 & ~full & ~flush
  - p2 = p1 & push_en2
  - Slot 1 is written at wr_ptr with push_pc. Slot 2 is written at wr_ptr+1 (wrapped) with push_pc+4; overflow of the 32-bit add wraps.
  - wr_ptr advances by p1+p2.
- Effective pops:
  - q1 = pop_en1 & out_valid1 & ~flush
  - q2 = q1 & pop_en2 & out_valid2
  - rd_ptr advances by q1+q2.
- Count update: count_next = count + (p1+p2) − (q1+q2). Push and pop in the same cycle are both honoured.
- Flush has priority over everything: wr_ptr, rd_ptr and count go to 0 on the next edge, and same-cycle pushes and pops are dropped.
- Outputs are first-word-fall-through and combinational from registered state:
  - out_valid1 = count >= 1
  - out_valid2 = count >= 2
  - out_pc1/out_inst1 read entry rd_ptr; out_pc2/out_inst2 read entry rd_ptr+1 (wrapped).
  - When a valid bit is 0, its pc/inst outputs are forced to 0.
- full = count > DEPTH−2. This is conservative, so a full 2-wide push always fits.
- empty = count == 0.
- Push when full is silently ignored (p1 = 0), even if a pop frees space that cycle.
- pop_en2 without pop_en1 is ignored. pop_en when not valid is ignored.
- No same-cycle bypass: an instruction pushed in cycle N is visible on the outputs in cycle N+1 at the earliest.

## Timing
- Reset (resetn low, asynchronous): wr_ptr=0, rd_ptr=0, count=0. This gives full=0, empty=1, out_valid1=out_valid2=0 and all out_pc/out_inst=0. Storage array contents are not reset.
- Reset asserted mid-operation clears the queue immediately, without waiting for an edge. The first push is accepted on the first rising edge after resetn deasserts.
- Latency: push to out_valid is 1 cycle. Pop to the next entry appearing at the head is 1 cycle.
- full and empty are derived from registered count and are glitch-free with respect to same-cycle inputs.
- Throughput: 2 in and 2 out per cycle sustained when 2 <= count <= DEPTH−2.
- Pointer wrap: entry DEPTH−1 is followed by entry 0, both for a slot-2 write and for the out_*2 read.

## Test plan
- Reset then dual push pc=0xBFC00000, inst 0x11111111/0x22222222 -> next cycle out_valid1=out_valid2=1, out_pc1=0xBFC00000, out_pc2=0xBFC00004, insts match; empty=0.
- Single push (push_en2=1 with push_en1=0 first, then push_en1 only) -> first cycle ignored (count stays 0); second yields count=1, out_valid2=0, out_pc2=0, out_inst2=0.
- Fill with dual pushes, no pops -> full=1 at count=15 (DEPTH=16, after 8th pair: count 16, full=1 from count 15); further push ignored; then pop 2/cycle drains in program order, empty=1 at end.
- Wrap: steady 2-in/1-out until pointers cross entry 15->0 -> out_pc1 increments strictly by 4, no loss or duplication; pair written at entries 15/0 reads back correctly.
- Flush with simultaneous push and pop at count=6 -> next cycle count=0, empty=1, out_valid1=0; pushed pair absent.
- resetn pulsed low mid-stream at count=5 -> outputs zero immediately (before the next edge); first post-reset push is at head.
